// File: rtl/lau_pkg.sv
// Shared types for the LAU arithmetic blocks.
package lau_pkg;

  // Prefix-network structure selection for arithmetic slices.
  typedef enum logic {
    SLOW,
    FAST
  } speed_e;

  // Control states of the iterative subtractor.
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_cz_iter_state_e;

  // Counter width able to index n chunks (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_cz_slice.sv
// Combinational chunk subtractor: s = a - b - bi, with borrow out and zero flag.
// Borrow chain is a PrefixAndOr network over (generate, propagate) pairs;
// FAST uses a log-depth parallel prefix, SLOW a serial ripple.
module sub_cz_slice
  import lau_pkg::*;
#(
  parameter int unsigned chunk = 16,
  parameter speed_e      speed = FAST
) (
  input  logic [chunk-1:0] a,
  input  logic [chunk-1:0] b,
  input  logic             bi,
  output logic [chunk-1:0] s,
  output logic             bo,
  output logic             zero
);

  logic [chunk-1:0] g;
  logic [chunk-1:0] p;
  logic [chunk-1:0] gp;
  logic [chunk-1:0] bin;

  // Per-bit borrow generate (a=0,b=1) and propagate (a==b).
  always_comb begin
    g = ~a & b;
    p = ~(a ^ b);
  end

  if (speed == FAST) begin : g_fast
    logic [chunk-1:0] gg;
    logic [chunk-1:0] pp;

    // Parallel prefix AND-OR; descending index keeps each stage reading old values.
    always_comb begin
      gg    = g;
      pp    = p;
      gg[0] = g[0] | (p[0] & bi);
      for (int unsigned d = 1; d < chunk; d = d * 2) begin
        for (int i = int'(chunk) - 1; i >= int'(d); i--) begin
          gg[i] = gg[i] | (pp[i] & gg[i-int'(d)]);
          pp[i] = pp[i] & pp[i-int'(d)];
        end
      end
      gp = gg;
    end
  end else begin : g_slow
    // Serial AND-OR ripple of the borrow.
    always_comb begin
      logic c;
      c  = bi;
      gp = '0;
      for (int i = 0; i < int'(chunk); i++) begin
        c     = g[i] | (p[i] & c);
        gp[i] = c;
      end
    end
  end

  // Borrow into each bit, difference, borrow out and zero detect.
  always_comb begin
    bin[0] = bi;
    for (int i = 1; i < int'(chunk); i++) begin
      bin[i] = gp[i-1];
    end
    s    = a ^ b ^ bin;
    bo   = gp[chunk-1];
    zero = ~|s;
  end

endmodule

// File: rtl/sub_cz_iter.sv
// Multi-cycle wide subtractor {co,s} = a - b - ci with borrow out and zero flag.
// Processes chunk bits per cycle, LSB chunk first, chaining borrow and zero
// through registers. Optional macro SUB_CZ_ITER_OVFL_EN adds signed overflow v.
module sub_cz_iter
  import lau_pkg::*;
#(
  parameter int unsigned width = 64,
  parameter int unsigned chunk = 16,
  parameter speed_e      speed = FAST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] s,
  output logic             co,
`ifdef SUB_CZ_ITER_OVFL_EN
  output logic             v,
`endif
  output logic             z
);

  localparam int unsigned N  = width / chunk;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  if (width % chunk != 0) begin : g_bad_chunk
    $error("sub_cz_iter: width must be a multiple of chunk");
  end

  sub_cz_iter_state_e state_q;
  sub_cz_iter_state_e state_d;
  logic [CW-1:0]      k_q;
  logic [width-1:0]   a_q;
  logic [width-1:0]   b_q;
  logic               br_q;
  logic               zacc_q;
  logic               accept;
  logic               last;
  logic [31:0]        off;
  logic [chunk-1:0]   sl_s;
  logic               sl_bo;
  logic               sl_zero;

  assign off = 32'(k_q) * chunk;

  sub_cz_slice #(
    .chunk (chunk),
    .speed (speed)
  ) u_slice (
    .a    (a_q[off +: chunk]),
    .b    (b_q[off +: chunk]),
    .bi   (br_q),
    .s    (sl_s),
    .bo   (sl_bo),
    .zero (sl_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (k_q == K_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, chunk counter and borrow/zero chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      zacc_q <= 1'b0;
    end else if (accept) begin
      k_q    <= '0;
      a_q    <= a;
      b_q    <= b;
      br_q   <= ci;
      zacc_q <= 1'b1;
    end else if (state_q == BUSY) begin
      k_q    <= last ? '0 : k_q + CW'(1);
      br_q   <= sl_bo;
      zacc_q <= zacc_q & sl_zero;
    end
  end

  // Registered outputs; co/z/v update on the final chunk and hold thereafter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      z         <= 1'b0;
`ifdef SUB_CZ_ITER_OVFL_EN
      v         <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (state_q == BUSY) begin
        s[off +: chunk] <= sl_s;
        if (last) begin
          co <= sl_bo;
          z  <= zacc_q & sl_zero;
`ifdef SUB_CZ_ITER_OVFL_EN
          v  <= (a_q[width-1] ^ b_q[width-1]) & (a_q[width-1] ^ sl_s[chunk-1]);
`endif
        end
      end
    end
  end

endmodule
